mem_load_unit: RTL and testbench
================================

# mem_load_unit

MEM-stage load unit. It accepts load requests from the MEM stage and issues a word read to data memory over a valid/ready request channel with a variable-latency response. It aligns and sign/zero-extends the returned word and holds the pipeline with `stall` until the result is ready. Its `wb_data` and `stall` outputs drive the data and stall inputs of the WB-stage data register directly; for non-load instructions the ALU result passes straight through.

## Interface
- `addrWidth`, default 16: data-memory byte-address width.

- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `ld_req` in 1: MEM-stage instruction is a load; held stable while `stall`=1.
- `ld_addr` in addrWidth: load byte address.
- `ld_funct3` in 3: load type. LB=000, LH=001, LW=010, LBU=100, LHU=101. Other codes are treated as LW.
- `pass_data` in 32: ALU/non-load write-back value.
- `dm_req` out 1: memory read request valid.
- `dm_addr` out addrWidth: request address, word-aligned (`[1:0]`=0).
- `dm_ready` in 1: memory accepts the request this cycle.
- `dm_rvalid` in 1: read data valid.
- `dm_rdata` in 32: read data.
- `stall` out 1: freeze the upstream pipeline and the WB data register.
- `wb_data` out 32: write-back value.
- `misalign` out 1: one-cycle pulse, misaligned load dropped.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. Reset state is IDLE.
- Alignment check on `ld_addr`:
  - LH/LHU are misaligned if `[0]`=1.
  - LW is misaligned if `[1:0]`≠0.
  - LB/LBU are never misaligned.
- IDLE:
  - `ld_req`=1 and aligned: capture addr, funct3 → REQ.
  - `ld_req`=1 and misaligned: no memory access, stay IDLE, set the `misalign` register.
  - Otherwise stay IDLE.
- REQ: `dm_req`=1 and `dm_addr`={captured addr[addrWidth-1:2], 2'b00}. On `dm_ready`=1 → WAIT. `dm_rvalid` in REQ is ignored.
- WAIT: on `dm_rvalid`=1, load the extracted value into `result` → DONE. No timeout.
- DONE: unconditionally → IDLE. `ld_req` is ignored here because it is the same load still presented.
- Extraction, with off = captured addr[1:0]:
  - LB: sign-extend byte `dm_rdata[8*off+7 : 8*off]`.
  - LBU: zero-extend the same byte.
  - LH: sign-extend halfword `dm_rdata[16*off[1]+15 : 16*off[1]]`.
  - LHU: zero-extend the same halfword.
  - LW: the full word.
- `stall` (combinational) = (IDLE & `ld_req` & aligned) | REQ | WAIT.
- `wb_data` (combinational):
  - DONE: `result`.
  - IDLE with `ld_req` & misaligned: 32'd0.
  - Otherwise: `pass_data`.
- `dm_rvalid` in IDLE or DONE is ignored and does not change `result`.

## Timing
- Reset values:
  - state = IDLE, `result` = 0, `misalign` = 0, `dm_req` = 0.
  - `dm_addr` = 0 (captured address register cleared).
  - `stall` follows its combinational equation; it is 0 when `ld_req`=0.
- Non-load: zero latency. `wb_data` = `pass_data` in the same cycle, `stall`=0.
- Best-case aligned load (`dm_ready` in the first REQ cycle, `dm_rvalid` one cycle later):
  - Cycle 0: IDLE with `ld_req`. `stall`=1.
  - Cycle 1: REQ, accepted.
  - Cycle 2: WAIT, `dm_rvalid`.
  - Cycle 3: DONE. `stall`=0, `wb_data`=`result`; captured by the WB register at the end of cycle 3.
- Each extra cycle of `dm_ready` low or `dm_rvalid` late adds one `stall` cycle.
- `misalign` is asserted in the cycle after the misaligned request, for exactly one cycle. Back-to-back misaligned loads produce consecutive pulses.
- Reset mid-operation (REQ/WAIT/DONE):
  - The FSM returns to IDLE and `dm_req` drops asynchronously.
  - `result` clears.
  - A response arriving after reset release is ignored.
- A new load is accepted no earlier than the cycle after DONE.

## Test plan
- Non-load: `ld_req`=0, `pass_data`=0x12345678 → `wb_data`=0x12345678 and `stall`=0 every cycle, `dm_req` never asserted.
- LB at addr 0x0003, `dm_rdata`=0x80FF_0102, immediate ready, rvalid +1 cycle:
  - `stall` high for exactly 3 cycles, `dm_addr`=0x0000.
  - In DONE, `wb_data`=0xFFFF_FF80.
  - Repeat as LBU → 0x0000_0080.
- LH at 0x0006, `dm_rdata`=0x8001_7FFF → 0xFFFF_8001. LHU at 0x0004 with the same data → 0x0000_7FFF.
- LW at 0x0010 with `dm_ready` low for 3 cycles and `dm_rvalid` 4 cycles after accept:
  - `stall` spans 1+4+4 = 9 cycles.
  - `dm_req` holds with `dm_addr` stable.
  - `wb_data`=`dm_rdata` in DONE.
  - A spurious `dm_rvalid` during REQ is ignored.
- Misaligned LW at 0x0002: no `dm_req`, `stall`=0, `wb_data`=0, `misalign` pulses one cycle later.
- Assert `rst` during WAIT, then pulse `dm_rvalid` after release: FSM in IDLE, `dm_req`=0, `result`=0, no DONE cycle.

Source files
------------

// File: rtl/mem_load_unit.sv
// MEM-stage load unit: issues word reads to data memory, aligns and extends the
// returned data, and stalls the pipeline until the write-back value is ready.
//
// state | meaning
// IDLE  | no load in flight; non-load values pass through
// REQ   | read request presented, waiting for dm_ready
// WAIT  | request accepted, waiting for dm_rvalid
// DONE  | result valid on wb_data for one cycle
module mem_load_unit #(
    parameter int addrWidth = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ld_req,
    input  logic [addrWidth-1:0] ld_addr,
    input  logic [2:0]           ld_funct3,
    input  logic [31:0]          pass_data,
    output logic                 dm_req,
    output logic [addrWidth-1:0] dm_addr,
    input  logic                 dm_ready,
    input  logic                 dm_rvalid,
    input  logic [31:0]          dm_rdata,
    output logic                 stall,
    output logic [31:0]          wb_data,
    output logic                 misalign
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t               state, state_nxt;
    logic [addrWidth-1:0] addr_q;
    logic [2:0]           funct3_q;
    logic [31:0]          result;
    logic                 aligned;
    logic                 accept;
    logic [1:0]           off;
    logic [7:0]           byte_sel;
    logic [15:0]          half_sel;
    logic [31:0]          extracted;

    always_comb begin
        aligned = 1'b1;
        case (ld_funct3)
            3'b000, 3'b100: aligned = 1'b1;
            3'b001, 3'b101: aligned = ~ld_addr[0];
            default:        aligned = (ld_addr[1:0] == 2'b00);
        endcase
    end

    assign accept = (state == IDLE) && ld_req && aligned;

    // Byte and halfword lanes are selected by the captured address offset.
    assign off      = addr_q[1:0];
    assign byte_sel = dm_rdata[{off, 3'b000} +: 8];
    assign half_sel = off[1] ? dm_rdata[31:16] : dm_rdata[15:0];

    always_comb begin
        extracted = dm_rdata;
        case (funct3_q)
            3'b000:  extracted = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  extracted = {24'd0, byte_sel};
            3'b001:  extracted = {{16{half_sel[15]}}, half_sel};
            3'b101:  extracted = {16'd0, half_sel};
            default: extracted = dm_rdata;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = REQ;
            REQ:     if (dm_ready) state_nxt = WAIT;
            WAIT:    if (dm_rvalid) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            funct3_q <= 3'b000;
            result   <= 32'd0;
            misalign <= 1'b0;
        end else begin
            state    <= state_nxt;
            misalign <= (state == IDLE) && ld_req && !aligned;
            if (accept) begin
                addr_q   <= ld_addr;
                funct3_q <= ld_funct3;
            end
            if (state == WAIT && dm_rvalid) begin
                result <= extracted;
            end
        end
    end

    assign dm_req  = (state == REQ);
    assign dm_addr = {addr_q[addrWidth-1:2], 2'b00};
    assign stall   = accept || (state == REQ) || (state == WAIT);

    always_comb begin
        wb_data = pass_data;
        if (state == DONE) begin
            wb_data = result;
        end else if ((state == IDLE) && ld_req && !aligned) begin
            wb_data = 32'd0;
        end
    end

endmodule

// File: tb/tb_mem_load_unit.sv
// Directed bench for mem_load_unit: pass-through, extended loads, memory
// back-pressure, misaligned drops and reset during an outstanding load.
module tb_mem_load_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_req;
    logic [15:0] ld_addr;
    logic [2:0]  ld_funct3;
    logic [31:0] pass_data;
    logic        dm_req;
    logic [15:0] dm_addr;
    logic        dm_ready;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        stall;
    logic [31:0] wb_data;
    logic        misalign;

    int total = 0;
    int bad   = 0;

    mem_load_unit dut (
        .clk       (clk),
        .rst       (rst),
        .ld_req    (ld_req),
        .ld_addr   (ld_addr),
        .ld_funct3 (ld_funct3),
        .pass_data (pass_data),
        .dm_req    (dm_req),
        .dm_addr   (dm_addr),
        .dm_ready  (dm_ready),
        .dm_rvalid (dm_rvalid),
        .dm_rdata  (dm_rdata),
        .stall     (stall),
        .wb_data   (wb_data),
        .misalign  (misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are checked 1ns later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input string tag, input logic [15:0] addr, input logic [2:0] f3,
                           input logic [31:0] rdata, input int ready_lo, input int wait_cyc,
                           input bit spurious, input logic [15:0] exp_daddr,
                           input logic [31:0] exp_wb, input int exp_stall);
        int nstall;
        nstall    = 0;
        ld_req    = 1'b1;
        ld_addr   = addr;
        ld_funct3 = f3;
        dm_ready  = 1'b0;
        dm_rvalid = 1'b0;
        dm_rdata  = 32'hDEAD_BEEF;
        #1;
        chk({tag, "_c0_stall"}, {31'd0, stall}, 32'd1);
        chk({tag, "_c0_dmreq"}, {31'd0, dm_req}, 32'd0);
        if (stall) nstall++;
        next_cycle();
        for (int i = 0; i <= ready_lo; i++) begin
            dm_ready  = (i == ready_lo);
            dm_rvalid = spurious && (i == 0);
            #1;
            chk({tag, "_req_dmreq"}, {31'd0, dm_req}, 32'd1);
            chk({tag, "_req_addr"}, {16'd0, dm_addr}, {16'd0, exp_daddr});
            if (stall) nstall++;
            next_cycle();
        end
        dm_ready = 1'b0;
        dm_rdata = rdata;
        for (int j = 1; j <= wait_cyc; j++) begin
            dm_rvalid = (j == wait_cyc);
            #1;
            chk({tag, "_wait_dmreq"}, {31'd0, dm_req}, 32'd0);
            if (stall) nstall++;
            next_cycle();
        end
        dm_rvalid = 1'b0;
        dm_rdata  = 32'h0BAD_0BAD;
        #1;
        chk({tag, "_done_stall"}, {31'd0, stall}, 32'd0);
        chk({tag, "_done_wb"}, wb_data, exp_wb);
        chk({tag, "_stall_cycles"}, nstall, exp_stall);
        next_cycle();
        ld_req = 1'b0;
        #1;
        chk({tag, "_after_wb"}, wb_data, pass_data);
        chk({tag, "_after_stall"}, {31'd0, stall}, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        ld_req    = 1'b0;
        ld_addr   = 16'h0000;
        ld_funct3 = 3'b000;
        pass_data = 32'h1234_5678;
        dm_ready  = 1'b0;
        dm_rvalid = 1'b0;
        dm_rdata  = 32'd0;
        #12;
        chk("rst_dmreq", {31'd0, dm_req}, 32'd0);
        chk("rst_dmaddr", {16'd0, dm_addr}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);
        chk("rst_result", dut.result, 32'd0);
        chk("rst_wb", wb_data, 32'h1234_5678);
        rst = 1'b0;
        next_cycle();

        // Non-load pass-through
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("pass_wb", wb_data, 32'h1234_5678);
            chk("pass_stall", {31'd0, stall}, 32'd0);
            chk("pass_dmreq", {31'd0, dm_req}, 32'd0);
            next_cycle();
        end

        do_load("lb3",   16'h0003, 3'b000, 32'h80FF_0102, 0, 1, 1'b0, 16'h0000, 32'hFFFF_FF80, 3);
        do_load("lbu3",  16'h0003, 3'b100, 32'h80FF_0102, 0, 1, 1'b0, 16'h0000, 32'h0000_0080, 3);
        do_load("lb1",   16'h0009, 3'b000, 32'h1122_3344, 0, 1, 1'b0, 16'h0008, 32'h0000_0033, 3);
        do_load("lh6",   16'h0006, 3'b001, 32'h8001_7FFF, 0, 1, 1'b0, 16'h0004, 32'hFFFF_8001, 3);
        do_load("lhu4",  16'h0004, 3'b101, 32'h8001_7FFF, 0, 1, 1'b0, 16'h0004, 32'h0000_7FFF, 3);
        do_load("lh4",   16'h0004, 3'b001, 32'h0000_9234, 0, 1, 1'b0, 16'h0004, 32'hFFFF_9234, 3);
        do_load("lw10",  16'h0010, 3'b010, 32'hCAFE_F00D, 3, 4, 1'b1, 16'h0010, 32'hCAFE_F00D, 9);

        // Misaligned LW, then back-to-back misaligned LHU
        pass_data = 32'hA5A5_A5A5;
        ld_req    = 1'b1;
        ld_addr   = 16'h0002;
        ld_funct3 = 3'b010;
        #1;
        chk("mis_dmreq", {31'd0, dm_req}, 32'd0);
        chk("mis_stall", {31'd0, stall}, 32'd0);
        chk("mis_wb", wb_data, 32'd0);
        chk("mis_pulse_early", {31'd0, misalign}, 32'd0);
        next_cycle();
        ld_addr   = 16'h0005;
        ld_funct3 = 3'b101;
        #1;
        chk("mis_pulse1", {31'd0, misalign}, 32'd1);
        chk("mis2_stall", {31'd0, stall}, 32'd0);
        chk("mis2_wb", wb_data, 32'd0);
        next_cycle();
        ld_req = 1'b0;
        #1;
        chk("mis_pulse2", {31'd0, misalign}, 32'd1);
        chk("mis2_dmreq", {31'd0, dm_req}, 32'd0);
        chk("mis2_wb_pass", wb_data, 32'hA5A5_A5A5);
        next_cycle();
        #1;
        chk("mis_pulse_end", {31'd0, misalign}, 32'd0);
        chk("mis_idle_dmreq", {31'd0, dm_req}, 32'd0);

        // Reset while WAIT, then a late response
        ld_req    = 1'b1;
        ld_addr   = 16'h0020;
        ld_funct3 = 3'b010;
        next_cycle();
        dm_ready = 1'b1;
        #1;
        chk("rw_req", {31'd0, dm_req}, 32'd1);
        next_cycle();
        dm_ready = 1'b0;
        #1;
        chk("rw_wait_stall", {31'd0, stall}, 32'd1);
        chk("rw_result_before", dut.result, 32'hCAFE_F00D);
        ld_req = 1'b0;
        rst    = 1'b1;
        #1;
        chk("rw_rst_dmreq", {31'd0, dm_req}, 32'd0);
        chk("rw_rst_stall", {31'd0, stall}, 32'd0);
        chk("rw_rst_result", dut.result, 32'd0);
        next_cycle();
        rst = 1'b0;
        next_cycle();
        dm_rvalid = 1'b1;
        dm_rdata  = 32'h7777_7777;
        #1;
        chk("rw_late_stall", {31'd0, stall}, 32'd0);
        next_cycle();
        dm_rvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("rw_no_done_wb", wb_data, 32'hA5A5_A5A5);
            chk("rw_no_dmreq", {31'd0, dm_req}, 32'd0);
            chk("rw_result_clear", dut.result, 32'd0);
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
